// File: rtl/shift_seq_ctrl.sv
// Sequencing controller for the bidirectional serial shift register: takes one
// command, drives a counted run of shifts from a pattern, then returns the captured contents.
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] cmd_pattern,
  input  logic             cmd_abort,
  output logic             sr_shift,
  output logic             sr_dir,
  output logic             sr_din,
  input  logic [WIDTH-1:0] sr_q,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_aborted,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshakes: a command transfers on the edge where cmd_valid && cmd_ready,
  // a response on the edge where rsp_valid && rsp_ready; valid never waits on ready.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t           state;
  logic             dir_q;
  logic [WIDTH-1:0] pat_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] idx;
  logic             aborted_q;
  logic             hold_dir;
  logic             hold_din;
  logic [CNT_W-1:0] cnt_sat;
  logic             din_sel;
  logic             in_shift;

  assign cnt_sat  = (cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_count;
  assign din_sel  = |(pat_q & (WIDTH'(1) << idx));
  assign in_shift = (state == SHIFT);

  // dir/din keep the last value driven in SHIFT so the register pins never glitch.
  assign sr_shift  = in_shift && !cmd_abort;
  assign sr_dir    = in_shift ? dir_q : hold_dir;
  assign sr_din    = in_shift ? din_sel : hold_din;
  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign rsp_valid = (state == RESP);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      dir_q       <= 1'b0;
      pat_q       <= '0;
      cnt_q       <= '0;
      idx         <= '0;
      aborted_q   <= 1'b0;
      hold_dir    <= 1'b0;
      hold_din    <= 1'b0;
      rsp_data    <= '0;
      rsp_aborted <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            dir_q     <= cmd_dir;
            pat_q     <= cmd_pattern;
            cnt_q     <= cnt_sat;
            idx       <= '0;
            aborted_q <= 1'b0;
            state     <= (cnt_sat != '0) ? SHIFT : CAPTURE;
          end
        end
        SHIFT: begin
          hold_dir <= dir_q;
          hold_din <= din_sel;
          // An abort suppresses this cycle's shift, including the final one.
          if (cmd_abort) begin
            aborted_q <= 1'b1;
            state     <= CAPTURE;
          end else begin
            idx <= idx + CNT_W'(1);
            if (idx == cnt_q - CNT_W'(1)) state <= CAPTURE;
          end
        end
        CAPTURE: begin
          rsp_data    <= sr_q;
          rsp_aborted <= aborted_q;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
